// File: rtl/custom_types_pkg.sv
// Shared type definitions for the ALU and its command sequencer.
//   alu_operation_t : operation select of the combinational alu
//   seq_op_t        : sequencer opcode; 0-5 mirror alu_operation_t, 6 = multiply, 7 = illegal
//   seq_state_t     : sequencer FSM states
package custom_types;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_LT  = 3'd5
  } alu_operation_t;

  typedef enum logic [2:0] {
    SEQ_ADD = 3'd0,
    SEQ_SUB = 3'd1,
    SEQ_AND = 3'd2,
    SEQ_OR  = 3'd3,
    SEQ_XOR = 3'd4,
    SEQ_LT  = 3'd5,
    SEQ_MUL = 3'd6,
    SEQ_ILL = 3'd7
  } seq_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } seq_state_t;

  // Opcodes 0-5 share the alu encoding, so the mapping is a plain retype.
  function automatic alu_operation_t to_alu_op(input seq_op_t op);
    return alu_operation_t'(3'(op));
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational datapath ALU.
//   op1, op2  : operands
//   operation : alu_operation_t select
//   result    : op1 <operation> op2, truncated to WIDTH (LT is unsigned, 0/1)
//   zero      : result == 0
module alu
  import custom_types::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  alu_operation_t   operation,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  // Operation decode
  always_comb begin
    result = '0;
    case (operation)
      ALU_ADD: result = op1 + op2;
      ALU_SUB: result = op1 - op2;
      ALU_AND: result = op1 & op2;
      ALU_OR:  result = op1 | op2;
      ALU_XOR: result = op1 ^ op2;
      ALU_LT:  result = WIDTH'(op1 < op2);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side master for the combinational alu.
//   clk, rst_n                      : clock, async active-low reset
//   cmd_valid/cmd_ready             : command handshake; cmd_op/cmd_a/cmd_b payload
//   alu_op1/alu_op2/alu_operation   : registered drive into the alu
//   alu_result/alu_zero             : alu outputs, captured at the end of EXEC/MUL
//   rsp_valid/rsp_ready             : response handshake; rsp_result/rsp_zero/rsp_err payload
//   busy                            : FSM not in IDLE
//   ops_done                        : completed response handshakes, wrapping
// Multiply is WIDTH rounds of shift-add routed through the alu adder.
module alu_cmd_sequencer
  import custom_types::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  seq_op_t          cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output alu_operation_t   alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int unsigned STEP_W = $clog2(WIDTH) + 1;

  seq_state_t       r_state,     w_state_nxt;
  logic [WIDTH-1:0] r_mcand,     w_mcand_nxt;
  logic [WIDTH-1:0] r_mplier,    w_mplier_nxt;
  logic [STEP_W-1:0] r_cnt,      w_cnt_nxt;
  // r_alu_op1 doubles as the multiply accumulator
  logic [WIDTH-1:0] r_alu_op1,   w_alu_op1_nxt;
  logic [WIDTH-1:0] r_alu_op2,   w_alu_op2_nxt;
  alu_operation_t   r_alu_oper,  w_alu_oper_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic [WIDTH-1:0] r_rsp_result, w_rsp_result_nxt;
  logic             r_rsp_zero,  w_rsp_zero_nxt;
  logic             r_rsp_err,   w_rsp_err_nxt;
  logic [CNT_W-1:0] r_ops_done,  w_ops_done_nxt;
  logic             r_cmd_ready, w_cmd_ready_nxt;
  logic             r_busy,      w_busy_nxt;

  // Multiplicand/multiplier as they will be after the current shift-add round
  logic [WIDTH-1:0] w_mcand_sh;
  logic [WIDTH-1:0] w_mplier_sh;
  assign w_mcand_sh  = r_mcand << 1;
  assign w_mplier_sh = r_mplier >> 1;

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_mcand_nxt      = r_mcand;
    w_mplier_nxt     = r_mplier;
    w_cnt_nxt        = r_cnt;
    w_alu_op1_nxt    = r_alu_op1;
    w_alu_op2_nxt    = r_alu_op2;
    w_alu_oper_nxt   = r_alu_oper;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_result_nxt = r_rsp_result;
    w_rsp_zero_nxt   = r_rsp_zero;
    w_rsp_err_nxt    = r_rsp_err;
    w_ops_done_nxt   = r_ops_done;

    case (r_state)
      IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          if (cmd_op == SEQ_MUL) begin
            // First round operands are presented straight from the command
            w_state_nxt    = MUL;
            w_mcand_nxt    = cmd_a;
            w_mplier_nxt   = cmd_b;
            w_cnt_nxt      = '0;
            w_alu_op1_nxt  = '0;
            w_alu_op2_nxt  = cmd_b[0] ? cmd_a : '0;
            w_alu_oper_nxt = ALU_ADD;
          end else if (cmd_op == SEQ_ILL) begin
            w_state_nxt      = RESP;
            w_rsp_valid_nxt  = 1'b1;
            w_rsp_result_nxt = '0;
            w_rsp_zero_nxt   = 1'b1;
            w_rsp_err_nxt    = 1'b1;
          end else begin
            w_state_nxt    = EXEC;
            w_alu_op1_nxt  = cmd_a;
            w_alu_op2_nxt  = cmd_b;
            w_alu_oper_nxt = to_alu_op(cmd_op);
          end
        end
      end

      EXEC: begin
        w_state_nxt      = RESP;
        w_rsp_valid_nxt  = 1'b1;
        w_rsp_result_nxt = alu_result;
        w_rsp_zero_nxt   = alu_zero;
        w_rsp_err_nxt    = 1'b0;
      end

      MUL: begin
        w_mcand_nxt   = w_mcand_sh;
        w_mplier_nxt  = w_mplier_sh;
        w_cnt_nxt     = r_cnt + STEP_W'(1);
        w_alu_op1_nxt = alu_result;
        w_alu_op2_nxt = w_mplier_sh[0] ? w_mcand_sh : '0;
        if (r_cnt == STEP_W'(WIDTH - 1)) begin
          w_state_nxt      = RESP;
          w_rsp_valid_nxt  = 1'b1;
          w_rsp_result_nxt = alu_result;
          w_rsp_zero_nxt   = alu_zero;
          w_rsp_err_nxt    = 1'b0;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_ops_done_nxt  = r_ops_done + CNT_W'(1);
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    // Handshake flags follow the state being entered, so they are valid for the whole cycle
    w_cmd_ready_nxt = (w_state_nxt == IDLE);
    w_busy_nxt      = (w_state_nxt != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_cnt        <= '0;
      r_alu_op1    <= '0;
      r_alu_op2    <= '0;
      r_alu_oper   <= ALU_ADD;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_ops_done   <= '0;
      r_cmd_ready  <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mcand      <= w_mcand_nxt;
      r_mplier     <= w_mplier_nxt;
      r_cnt        <= w_cnt_nxt;
      r_alu_op1    <= w_alu_op1_nxt;
      r_alu_op2    <= w_alu_op2_nxt;
      r_alu_oper   <= w_alu_oper_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_result <= w_rsp_result_nxt;
      r_rsp_zero   <= w_rsp_zero_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
      r_ops_done   <= w_ops_done_nxt;
      r_cmd_ready  <= w_cmd_ready_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign busy          = r_busy;
  assign alu_op1       = r_alu_op1;
  assign alu_op2       = r_alu_op2;
  assign alu_operation = r_alu_oper;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_result    = r_rsp_result;
  assign rsp_zero      = r_rsp_zero;
  assign rsp_err       = r_rsp_err;
  assign ops_done      = r_ops_done;

endmodule
